div_ctrl: RTL and testbench

- Sequences the shared iterative unsigned divider for the RV32M DIV/DIVU/REM/REMU instructions issued from the execute stage.
- Takes the signed or unsigned operands, converts them to magnitudes and runs the divider's start/done handshake. It then applies result signs and returns one 32-bit result.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Caches the last quotient/remainder pair so that DIV followed by REM on the same operands completes without re-dividing.

---
 rtl/div_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_div_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Sequencer for the shared iterative unsigned divider serving the
//             RV32M DIV/DIVU/REM/REMU instructions. Converts signed operands
//             to magnitudes, runs the divider start/done handshake, restores
//             result signs and returns a single 32-bit result. Divide-by-zero
//             and signed overflow are resolved locally. The last
//             quotient/remainder pair is kept so that DIV followed by REM
//             (or the reverse) on identical operands skips the divider.
//
//  Ports    :
//    clk         in   1   clock
//    rst_n       in   1   synchronous active-low reset
//    req_valid   in   1   EX has a divide op (held stable until resp_valid)
//    req_op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//    req_rs1     in  32   dividend
//    req_rs2     in  32   divisor
//    flush       in   1   kill the in-flight op, no response produced
//    busy        out  1   pipeline stall while an accepted op is pending
//    resp_valid  out  1   single-cycle result strobe
//    resp_data   out 32   result, held until the next response
//    div_start   out  1   divider start
//    div_a       out 32   dividend magnitude to divider
//    div_b       out 32   divisor magnitude to divider
//    div_done    in   1   divider idle
//    div_quo     in  32   divider quotient
//    div_rem     in  32   divider remainder
//
//  Revision : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int unsigned CACHE_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_quo,
    input  logic [31:0] div_rem
);

    localparam logic        c_cache_en  = (CACHE_EN != 0);
    localparam logic [31:0] c_int_min   = 32'h8000_0000;
    localparam logic [31:0] c_all_ones  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_FIX    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Latched operation context (valid from accept until response).
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_signed;
    logic        r_is_rem;
    logic        r_quo_neg;
    logic        r_rem_neg;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_killed;
    logic [31:0] r_resp_data;

    // Set once div_done has been seen high after reset; a reset may land
    // while the divider is mid-run, and it must drain before a new start.
    logic        r_drained;

    // Result cache.
    logic        r_c_valid;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic        r_c_signed;
    logic [31:0] r_c_quo;
    logic [31:0] r_c_rem;

    // Request decode.
    logic        w_signed;
    logic        w_is_rem;
    logic [31:0] w_rs1_mag;
    logic [31:0] w_rs2_mag;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_hit;
    logic        w_launch_ok;
    logic        w_req;

    // FSM decisions.
    logic        w_accept_fast;
    logic        w_accept_div;
    logic [31:0] w_fast_data;
    logic        w_fix_commit;

    // Sign-corrected divider results.
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;

    assign w_signed    = ~req_op[0];
    assign w_is_rem    = req_op[1];
    assign w_req       = req_valid & ~flush;

    // Negating 0x80000000 wraps back to itself, which is the magnitude the
    // unsigned divider needs for INT_MIN.
    assign w_rs1_mag   = (w_signed & req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
    assign w_rs2_mag   = (w_signed & req_rs2[31]) ? (32'd0 - req_rs2) : req_rs2;

    assign w_div_zero  = (req_rs2 == 32'd0);
    assign w_overflow  = w_signed & (req_rs1 == c_int_min) & (req_rs2 == c_all_ones);
    assign w_hit       = c_cache_en & r_c_valid
                       & (req_rs1 == r_c_rs1)
                       & (req_rs2 == r_c_rs2)
                       & (w_signed == r_c_signed);
    assign w_launch_ok = r_drained | div_done;

    assign w_quo_s     = r_quo_neg ? (32'd0 - r_quo) : r_quo;
    assign w_rem_s     = r_rem_neg ? (32'd0 - r_rem) : r_rem;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_accept_fast = 1'b0;
        w_accept_div  = 1'b0;
        w_fast_data   = 32'd0;
        w_fix_commit  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_div_zero) begin
                        w_accept_fast = 1'b1;
                        w_fast_data   = w_is_rem ? req_rs1 : c_all_ones;
                    end else if (w_overflow) begin
                        w_accept_fast = 1'b1;
                        w_fast_data   = w_is_rem ? 32'd0 : c_int_min;
                    end else if (w_hit) begin
                        w_accept_fast = 1'b1;
                        w_fast_data   = w_is_rem ? r_c_rem : r_c_quo;
                    end else if (w_launch_ok) begin
                        w_accept_div  = 1'b1;
                    end
                end
                if (w_accept_fast) begin
                    w_state_nxt = S_RESP;
                end else if (w_accept_div) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Hold start until the divider acknowledges by dropping done.
                if (!div_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (div_done) begin
                    w_state_nxt = (r_killed | flush) ? S_IDLE : S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fix_commit = 1'b1;
                    w_state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_signed    <= 1'b0;
            r_is_rem    <= 1'b0;
            r_quo_neg   <= 1'b0;
            r_rem_neg   <= 1'b0;
            r_div_a     <= 32'd0;
            r_div_b     <= 32'd0;
            r_quo       <= 32'd0;
            r_rem       <= 32'd0;
            r_killed    <= 1'b0;
            r_resp_data <= 32'd0;
            r_drained   <= 1'b0;
            r_c_valid   <= 1'b0;
            r_c_rs1     <= 32'd0;
            r_c_rs2     <= 32'd0;
            r_c_signed  <= 1'b0;
            r_c_quo     <= 32'd0;
            r_c_rem     <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_drained <= r_drained | div_done;

            if (w_accept_fast) begin
                r_resp_data <= w_fast_data;
            end

            if (w_accept_div) begin
                r_rs1     <= req_rs1;
                r_rs2     <= req_rs2;
                r_signed  <= w_signed;
                r_is_rem  <= w_is_rem;
                r_quo_neg <= w_signed & (req_rs1[31] ^ req_rs2[31]);
                r_rem_neg <= w_signed & req_rs1[31];
                r_div_a   <= w_rs1_mag;
                r_div_b   <= w_rs2_mag;
            end

            // A flush during the handshake cannot abort the divider, so it
            // is remembered and applied once the divider finishes.
            if (r_state == S_IDLE) begin
                r_killed <= 1'b0;
            end else if (flush && (r_state == S_LAUNCH || r_state == S_RUN)) begin
                r_killed <= 1'b1;
            end

            if (r_state == S_RUN && div_done) begin
                r_quo <= div_quo;
                r_rem <= div_rem;
            end

            if (w_fix_commit) begin
                r_resp_data <= r_is_rem ? w_rem_s : w_quo_s;
                if (c_cache_en) begin
                    r_c_valid  <= 1'b1;
                    r_c_rs1    <= r_rs1;
                    r_c_rs2    <= r_rs2;
                    r_c_signed <= r_signed;
                    r_c_quo    <= w_quo_s;
                    r_c_rem    <= w_rem_s;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The IDLE term raises busy in the accept cycle and also stalls a
    // request that is waiting for the divider to drain after reset.
    assign busy       = (r_state != S_IDLE) | w_req;
    assign resp_valid = (r_state == S_RESP) & ~flush;
    assign resp_data  = r_resp_data;
    assign div_start  = (r_state == S_LAUNCH);
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl with a behavioural iterative
//             divider attached. Table-driven transactions plus hand-written
//             flush and reset-while-running sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

    localparam int c_div_cycles = 8;
    localparam int c_max_wait   = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done = 1'b1;
    logic [31:0] div_quo  = 32'd0;
    logic [31:0] div_rem  = 32'd0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    div_ctrl #(.CACHE_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_quo    (div_quo),
        .div_rem    (div_rem)
    );

    // ---------------- behavioural divider (not reset by rst_n) ----------
    int          dcnt = 0;
    logic [31:0] lat_a = 32'd0;
    logic [31:0] lat_b = 32'd0;
    logic        stab_en = 1'b0;
    int          stab_err = 0;
    int          start_err = 0;
    logic        prev_start = 1'b0;

    always @(posedge clk) begin
        if (div_done && div_start) begin
            div_done <= 1'b0;
            dcnt     <= c_div_cycles;
            lat_a    <= div_a;
            lat_b    <= div_b;
            stab_en  <= 1'b1;
        end else if (!div_done) begin
            if (dcnt == 1) begin
                div_done <= 1'b1;
                div_quo  <= (div_b != 32'd0) ? div_a / div_b : 32'hFFFF_FFFF;
                div_rem  <= (div_b != 32'd0) ? div_a % div_b : div_a;
                stab_en  <= 1'b0;
            end
            dcnt <= dcnt - 1;
        end
        if (!rst_n) stab_en <= 1'b0;
    end

    // Operands must not move while the divider iterates; a new start must
    // only begin when the divider is idle.
    always @(negedge clk) begin
        if (rst_n && stab_en && !div_done && (div_a != lat_a || div_b != lat_b))
            stab_err++;
        if (div_start && !prev_start && !div_done)
            start_err++;
        prev_start = div_start;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
        int lat;
        int starts;
        bit got;
        lat = 0; starts = 0; got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
        #1;
        check({name, "_busy_acc"}, 32'(busy), 32'd1);
        while (!got && lat < c_max_wait) begin
            @(posedge clk); #1;
            lat++;
            if (div_start) starts++;
            if (resp_valid) got = 1'b1;
        end
        check({name, "_resp_seen"}, 32'(got), 32'd1);
        check({name, "_data"}, resp_data, exp);
        if (fast) begin
            check({name, "_lat"}, 32'(lat), 32'd1);
            check({name, "_nostart"}, 32'(starts), 32'd0);
        end else begin
            check({name, "_started"}, 32'(starts > 0), 32'd1);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_strobe1"}, 32'(resp_valid), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_hold"}, resp_data, exp);
    endtask

    task automatic wait_running(input string name);
        int n;
        n = 0;
        while (div_done && n < 50) begin @(negedge clk); n++; end
        check({name, "_divrun"}, 32'(div_done), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        1'b0};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         1'b1};
        vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  1'b1};
        vecs[4]  = '{2'b00, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1};
        vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'd5,         1'b1};
        vecs[6]  = '{2'b01, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1};
        vecs[7]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
        vecs[8]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b1};
        vecs[9]  = '{2'b01, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0};
        vecs[10] = '{2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
        vecs[11] = '{2'b00, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0};
        vecs[12] = '{2'b10, 32'd100,       32'hFFFFFFF9,  32'd2,         1'b1};
        vecs[13] = '{2'b00, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0};
        vecs[14] = '{2'b01, 32'hFFFFFF9C,  32'd7,         32'h24924916,  1'b0};
        vecs[15] = '{2'b11, 32'hFFFFFF9C,  32'd7,         32'd2,         1'b1};
        vecs[16] = '{2'b00, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0};
        vecs[17] = '{2'b11, 32'd100,       32'd7,         32'd2,         1'b0};
        vecs[18] = '{2'b00, 32'h80000000,  32'd1,         32'h80000000,  1'b0};
        vecs[19] = '{2'b10, 32'h80000000,  32'd1,         32'd0,         1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        req_rs1 = 32'd0; req_rs2 = 32'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {29'd0, busy, resp_valid, div_start}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_a", div_a, 32'd0);
        check("rst_b", div_b, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 20; i++)
            do_req($sformatf("v%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].exp, vecs[i].fast);

        // ---- flush while the divider runs ----
        begin
            bit seen_resp;
            bit early_drop;
            int n;
            seen_resp = 1'b0; early_drop = 1'b0; n = 0;
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3;
            wait_running("flush");
            flush = 1'b1; req_valid = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            while (busy && n < c_max_wait) begin
                if (!div_done && !busy) early_drop = 1'b1;
                if (resp_valid) seen_resp = 1'b1;
                @(negedge clk); n++;
                if (!busy && !div_done) early_drop = 1'b1;
            end
            check("flush_noresp", 32'(seen_resp), 32'd0);
            check("flush_busy_held", 32'(early_drop), 32'd0);
            check("flush_released", 32'(busy), 32'd0);
        end
        do_req("flush_rerun", 2'b01, 32'd1000, 32'd3, 32'd333, 1'b0);

        // ---- reset while the divider runs ----
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd7;
        wait_running("mrst");
        rst_n = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check("mrst_ctrl", {29'd0, busy, resp_valid, div_start}, 32'd0);
        check("mrst_data", resp_data, 32'd0);
        check("mrst_ab", div_a | div_b, 32'd0);
        check("mrst_div_busy", 32'(div_done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        // Cache was cleared by reset, so this must re-divide.
        do_req("mrst_new", 2'b11, 32'd1000, 32'd3, 32'd1, 1'b0);
        do_req("mrst_hit", 2'b01, 32'd1000, 32'd3, 32'd333, 1'b1);

        check("operand_stability", 32'(stab_err), 32'd0);
        check("start_while_busy", 32'(start_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
